pixel_serializer: RTL and testbench
===================================

# pixel_serializer

Converts the 8-bit row slices produced by the character generator into a serial pixel stream for the VGA output stage. It double-buffers one slice behind the one being shifted, applies per-character colour, flash and conceal attributes, and drives registered 12-bit RGB. The block sits directly downstream of the character generator and upstream of the VGA DAC pins.

## Interface
- FLASH_ON_FRAMES, 48, frames during which flashing characters are visible
- FLASH_OFF_FRAMES, 16, frames during which flashing characters are hidden (foreground shown as background)
- clk  in  1  pixel-domain clock
- reset_n  in  1  asynchronous, active-low reset
- row_pixels  in  8  pixel slice; bit 7 is the leftmost pixel
- fg_color  in  3  foreground colour; bit0 red, bit1 green, bit2 blue
- bg_color  in  3  background colour, same encoding
- flash  in  1  slice belongs to a flashing character
- conceal  in  1  slice belongs to a concealed character
- load_valid  in  1  slice and attributes on the inputs are valid
- load_ready  out  1  holding register empty; slice accepted when load_valid && load_ready
- pixel_en  in  1  advance one pixel this cycle
- blank  in  1  outside the active area; forces black output
- frame_start  in  1  one-cycle pulse per frame; advances the flash counter
- reveal  in  1  global override that shows concealed characters
- clear_underrun  in  1  clears the underrun flag
- vga_r, vga_g, vga_b  out  4 each  registered pixel colour
- underrun  out  1  sticky: pixel_en arrived with no pixel available

## Operation
- Storage:
  - Holding register `hold`: 8 pixel bits plus fg, bg, flash and conceal, with a `hold_full` flag.
  - Shift register `shift`: 8 bits plus latched attributes and a count of 0..8 pixels remaining.
- load_ready = !hold_full. Driven from a register only; there is no combinational path from pixel_en.
- Load: on load_valid && load_ready, capture the inputs into `hold` and set hold_full.
- On each pixel_en cycle, exactly one case applies:
  - count > 0: emit shift[7] with the shift attributes; shift left by 1; count decrements by 1.
  - count == 0 and hold_full: emit hold[7] with the hold attributes; shift <= hold << 1; count <= 7; attributes move from hold to shift; hold_full clears.
  - count == 0 and !hold_full (underrun): emit black and set underrun.
- Back-to-back slices produce no bubble: a count-1 pixel is followed on the next pixel_en by the hold slice.
- A load in the same cycle as a transfer is impossible, because a load requires hold_full = 0 and a transfer requires hold_full = 1.
- Colour selection for an emitted pixel bit b:
  - fg_vis = b && !(flash && !flash_visible) && !(conceal && !reveal)
  - colour = fg_vis ? fg : bg
  - Each colour bit expands to 4'hF or 4'h0 on its channel.
  - blank = 1 forces 0/0/0 regardless of colour selection.
- blank does not stop shifting; pixel_en alone controls the shift.
- Flash counter:
  - 7-bit counter; increments on frame_start.
  - Wraps from FLASH_ON_FRAMES+FLASH_OFF_FRAMES-1 to 0.
  - flash_visible = counter < FLASH_ON_FRAMES.
- underrun is sticky. If it is set and cleared in the same cycle, set wins.
- Reset (asynchronous, any time, including mid-slice):
  - hold_full = 0, so load_ready = 1
  - count = 0, shift = 0
  - flash counter = 0, so flash_visible = 1
  - vga_r/g/b = 0
  - underrun = 0
  - Any in-flight slice is discarded.

## Timing
- vga_r/g/b update on the clock edge of the pixel_en cycle: 1-cycle latency from pixel_en to pixel.
- Without pixel_en the outputs hold their last value.
- blank is sampled in the pixel_en cycle. A blank change without pixel_en does not update the outputs.
- load_ready falls the cycle after an accepted load and rises the cycle after a transfer into shift.
- frame_start takes effect on flash_visible the cycle after the pulse, so a pixel emitted in that same cycle uses the old phase.
- underrun asserts the cycle after the underrunning pixel_en.

## Test plan
- **Reset:** hold reset_n = 0 → vga = 0, load_ready = 1, underrun = 0. Release, then pulse pixel_en once with nothing loaded → vga = 0 and underrun = 1.
- **Serialization:** load 8'b1010_0001 with fg = 3'b001, bg = 3'b100, then 8 consecutive pixel_en → vga_r,vga_b sequence (F,0),(0,F),(F,0),(0,F),(0,F),(0,F),(0,F),(F,0).
- **Back-to-back:** load slice A (8'hFF, fg = 7), and when load_ready rises load B (8'h00, bg = 2), with pixel_en asserted every cycle for 16 cycles → 8 white pixels then 8 green pixels, no gap, underrun stays 0.
- **Flash:** slice 8'hFF, fg = 7, bg = 0, flash = 1. Issue 48 frame_start pulses, then emit a pixel → black. Issue 16 more pulses, then emit → white.
- **Conceal/blank:** conceal = 1, reveal = 0 → all pixels bg. Same slice with reveal = 1 → fg pattern. Same slice with blank = 1 → 0 while count still advances: after 8 pixel_en, count = 0.
- **Mid-slice reset:** assert reset_n = 0 after 3 of 8 pixels with hold full → load_ready = 1 and count = 0 after release. The next pixel_en yields black and underrun = 1, and none of the old pixels reappear.

Source files
------------

// File: rtl/pixel_serializer.sv
// pixel_serializer
// Turns 8-bit character row slices into a serial pixel stream with colour,
// flash and conceal attributes applied, producing registered 12-bit RGB.
// One slice is double-buffered in a holding register behind the slice that
// is currently being shifted out, so consecutive slices stream with no gap.
//
// Load handshake: a slice (row_pixels plus its attributes) transfers into the
// holding register on any rising clock edge where load_valid && load_ready.
// load_ready is the registered inverse of hold_full and never depends
// combinationally on load_valid or pixel_en. The producer keeps the slice
// stable while load_valid is high and load_ready is low.
//
// Debug outputs expose the pixel count of the shifter and the flash frame
// counter so their state can be observed directly.

module pixel_serializer #(
   parameter int FLASH_ON_FRAMES  = 48,
   parameter int FLASH_OFF_FRAMES = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] row_pixels,
   input  logic [2:0] fg_color,
   input  logic [2:0] bg_color,
   input  logic       flash,
   input  logic       conceal,
   input  logic       load_valid,
   output logic       load_ready,
   input  logic       pixel_en,
   input  logic       blank,
   input  logic       frame_start,
   input  logic       reveal,
   input  logic       clear_underrun,
   output logic [3:0] vga_r,
   output logic [3:0] vga_g,
   output logic [3:0] vga_b,
   output logic       underrun,
   output logic [3:0] dbg_count,
   output logic [6:0] dbg_flash_cnt
);

   // Last value of the flash frame counter before it wraps to zero.
   localparam logic [6:0] FLASH_LAST = 7'(FLASH_ON_FRAMES + FLASH_OFF_FRAMES - 1);
   // Counter values below this threshold show flashing foreground.
   localparam logic [6:0] FLASH_ON   = 7'(FLASH_ON_FRAMES);

   // Holding register: the slice waiting behind the one being shifted.
   logic [7:0] hold_pix_q,     hold_pix_d;
   logic [2:0] hold_fg_q,      hold_fg_d;
   logic [2:0] hold_bg_q,      hold_bg_d;
   logic       hold_flash_q,   hold_flash_d;
   logic       hold_conceal_q, hold_conceal_d;
   logic       hold_full_q,    hold_full_d;

   // Shift register: the slice currently being emitted, MSB first.
   logic [7:0] shift_pix_q,     shift_pix_d;
   logic [2:0] shift_fg_q,      shift_fg_d;
   logic [2:0] shift_bg_q,      shift_bg_d;
   logic       shift_flash_q,   shift_flash_d;
   logic       shift_conceal_q, shift_conceal_d;
   logic [3:0] count_q,         count_d;

   // Flash phase, output pixel and sticky underrun flag.
   logic [6:0] flash_cnt_q, flash_cnt_d;
   logic [3:0] vga_r_q,     vga_r_d;
   logic [3:0] vga_g_q,     vga_g_d;
   logic [3:0] vga_b_q,     vga_b_d;
   logic       underrun_q,  underrun_d;

   // The pixel selected for emission in the current pixel_en cycle.
   logic       emit_valid;
   logic       emit_bit;
   logic [2:0] emit_fg;
   logic [2:0] emit_bg;
   logic       emit_flash;
   logic       emit_conceal;
   logic       starve;
   logic       transfer;
   logic       load_fire;

   logic       flash_visible;
   logic       fg_vis;
   logic [2:0] colour;

   // A transfer happens when the shifter is empty and a slice is waiting.
   // It needs hold_full = 1, a load needs hold_full = 0, so the two never
   // coincide.
   assign transfer  = pixel_en && (count_q == 4'd0) && hold_full_q;
   assign load_fire = load_valid && !hold_full_q;

   // Holding register: capture on an accepted load, empty on a transfer.
   always_comb begin
      hold_pix_d     = hold_pix_q;
      hold_fg_d      = hold_fg_q;
      hold_bg_d      = hold_bg_q;
      hold_flash_d   = hold_flash_q;
      hold_conceal_d = hold_conceal_q;
      hold_full_d    = hold_full_q;
      if (load_fire) begin
         hold_pix_d     = row_pixels;
         hold_fg_d      = fg_color;
         hold_bg_d      = bg_color;
         hold_flash_d   = flash;
         hold_conceal_d = conceal;
         hold_full_d    = 1'b1;
      end else if (transfer) begin
         hold_full_d    = 1'b0;
      end
   end

   // Shifter: pick the pixel to emit and advance the shift/count state.
   always_comb begin
      shift_pix_d     = shift_pix_q;
      shift_fg_d      = shift_fg_q;
      shift_bg_d      = shift_bg_q;
      shift_flash_d   = shift_flash_q;
      shift_conceal_d = shift_conceal_q;
      count_d         = count_q;
      emit_valid      = 1'b0;
      emit_bit        = 1'b0;
      emit_fg         = 3'd0;
      emit_bg         = 3'd0;
      emit_flash      = 1'b0;
      emit_conceal    = 1'b0;
      starve          = 1'b0;
      if (pixel_en) begin
         if (count_q != 4'd0) begin
            // Mid-slice: emit the MSB of the shifter.
            emit_valid   = 1'b1;
            emit_bit     = shift_pix_q[7];
            emit_fg      = shift_fg_q;
            emit_bg      = shift_bg_q;
            emit_flash   = shift_flash_q;
            emit_conceal = shift_conceal_q;
            shift_pix_d  = {shift_pix_q[6:0], 1'b0};
            count_d      = count_q - 4'd1;
         end else if (hold_full_q) begin
            // Shifter empty: emit straight from the holding register so the
            // first pixel of the next slice follows without a bubble.
            emit_valid      = 1'b1;
            emit_bit        = hold_pix_q[7];
            emit_fg         = hold_fg_q;
            emit_bg         = hold_bg_q;
            emit_flash      = hold_flash_q;
            emit_conceal    = hold_conceal_q;
            shift_pix_d     = {hold_pix_q[6:0], 1'b0};
            shift_fg_d      = hold_fg_q;
            shift_bg_d      = hold_bg_q;
            shift_flash_d   = hold_flash_q;
            shift_conceal_d = hold_conceal_q;
            count_d         = 4'd7;
         end else begin
            // Nothing to show: black pixel and flag the underrun.
            starve = 1'b1;
         end
      end
   end

   // Colour selection and output pixel register update.
   always_comb begin
      flash_visible = (flash_cnt_q < FLASH_ON);
      fg_vis        = emit_bit
                      && !(emit_flash && !flash_visible)
                      && !(emit_conceal && !reveal);
      colour        = fg_vis ? emit_fg : emit_bg;
      vga_r_d       = vga_r_q;
      vga_g_d       = vga_g_q;
      vga_b_d       = vga_b_q;
      if (pixel_en) begin
         if (blank || !emit_valid) begin
            vga_r_d = 4'h0;
            vga_g_d = 4'h0;
            vga_b_d = 4'h0;
         end else begin
            vga_r_d = {4{colour[0]}};
            vga_g_d = {4{colour[1]}};
            vga_b_d = {4{colour[2]}};
         end
      end
   end

   // Sticky underrun: a new underrun beats a simultaneous clear.
   always_comb begin
      underrun_d = (underrun_q && !clear_underrun) || starve;
   end

   // Flash frame counter, advancing once per frame and wrapping.
   always_comb begin
      flash_cnt_d = flash_cnt_q;
      if (frame_start) begin
         if (flash_cnt_q == FLASH_LAST) begin
            flash_cnt_d = 7'd0;
         end else begin
            flash_cnt_d = flash_cnt_q + 7'd1;
         end
      end
   end

   // State registers; reset discards any slice in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_pix_q      <= 8'd0;
         hold_fg_q       <= 3'd0;
         hold_bg_q       <= 3'd0;
         hold_flash_q    <= 1'b0;
         hold_conceal_q  <= 1'b0;
         hold_full_q     <= 1'b0;
         shift_pix_q     <= 8'd0;
         shift_fg_q      <= 3'd0;
         shift_bg_q      <= 3'd0;
         shift_flash_q   <= 1'b0;
         shift_conceal_q <= 1'b0;
         count_q         <= 4'd0;
         flash_cnt_q     <= 7'd0;
         vga_r_q         <= 4'h0;
         vga_g_q         <= 4'h0;
         vga_b_q         <= 4'h0;
         underrun_q      <= 1'b0;
      end else begin
         hold_pix_q      <= hold_pix_d;
         hold_fg_q       <= hold_fg_d;
         hold_bg_q       <= hold_bg_d;
         hold_flash_q    <= hold_flash_d;
         hold_conceal_q  <= hold_conceal_d;
         hold_full_q     <= hold_full_d;
         shift_pix_q     <= shift_pix_d;
         shift_fg_q      <= shift_fg_d;
         shift_bg_q      <= shift_bg_d;
         shift_flash_q   <= shift_flash_d;
         shift_conceal_q <= shift_conceal_d;
         count_q         <= count_d;
         flash_cnt_q     <= flash_cnt_d;
         vga_r_q         <= vga_r_d;
         vga_g_q         <= vga_g_d;
         vga_b_q         <= vga_b_d;
         underrun_q      <= underrun_d;
      end
   end

   assign load_ready    = !hold_full_q;
   assign vga_r         = vga_r_q;
   assign vga_g         = vga_g_q;
   assign vga_b         = vga_b_q;
   assign underrun      = underrun_q;
   assign dbg_count     = count_q;
   assign dbg_flash_cnt = flash_cnt_q;

endmodule

// File: tb/tb_pixel_serializer.sv
// Bench for pixel_serializer. The reference model keeps every pixel that has
// been accepted but not yet shown in one queue (oldest first) and a plain
// frame counter for the flash phase; the DUT's holding register is full
// exactly when 8 or more pixels are pending.

module tb_pixel_serializer;

   localparam int FLASH_ON  = 48;
   localparam int FLASH_OFF = 16;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic [7:0] row_pixels;
   logic [2:0] fg_color;
   logic [2:0] bg_color;
   logic       flash;
   logic       conceal;
   logic       load_valid;
   logic       load_ready;
   logic       pixel_en;
   logic       blank;
   logic       frame_start;
   logic       reveal;
   logic       clear_underrun;
   logic [3:0] vga_r;
   logic [3:0] vga_g;
   logic [3:0] vga_b;
   logic       underrun;
   logic [3:0] dbg_count;
   logic [6:0] dbg_flash_cnt;

   pixel_serializer #(
      .FLASH_ON_FRAMES  (FLASH_ON),
      .FLASH_OFF_FRAMES (FLASH_OFF)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .row_pixels     (row_pixels),
      .fg_color       (fg_color),
      .bg_color       (bg_color),
      .flash          (flash),
      .conceal        (conceal),
      .load_valid     (load_valid),
      .load_ready     (load_ready),
      .pixel_en       (pixel_en),
      .blank          (blank),
      .frame_start    (frame_start),
      .reveal         (reveal),
      .clear_underrun (clear_underrun),
      .vga_r          (vga_r),
      .vga_g          (vga_g),
      .vga_b          (vga_b),
      .underrun       (underrun),
      .dbg_count      (dbg_count),
      .dbg_flash_cnt  (dbg_flash_cnt)
   );

   // Clock
   always #5 clk = ~clk;

   // Scoreboard state: pending pixels {bit, fg, bg, flash, conceal}
   logic [8:0]  exp_q[$];
   int          frames;
   logic [11:0] exp_vga;
   logic        exp_underrun;
   logic        last_accept;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Colour rule applied to one pending pixel.
   function automatic logic [11:0] colour_of(input logic [8:0] p, input bit vis,
                                              input bit rev, input bit blk);
      logic       show;
      logic [2:0] c;
      show = p[8] && !(p[1] && !vis) && !(p[0] && !rev);
      c    = show ? p[7:5] : p[4:2];
      if (blk) return 12'h000;
      return {{4{c[0]}}, {4{c[1]}}, {4{c[2]}}};
   endfunction

   task automatic push_slice(input logic [7:0] row, input logic [2:0] fg,
                             input logic [2:0] bg, input logic fl, input logic cn);
      for (int i = 7; i >= 0; i--) exp_q.push_back({row[i], fg, bg, fl, cn});
   endtask

   task automatic idle();
      row_pixels     = 8'd0;
      fg_color       = 3'd0;
      bg_color       = 3'd0;
      flash          = 1'b0;
      conceal        = 1'b0;
      load_valid     = 1'b0;
      pixel_en       = 1'b0;
      blank          = 1'b0;
      frame_start    = 1'b0;
      reveal         = 1'b0;
      clear_underrun = 1'b0;
   endtask

   // One clock with the current inputs; called and returns at a negedge.
   task automatic tick();
      bit         ready_m;
      bit         vis;
      bit         starve;
      logic [8:0] p;
      ready_m = (exp_q.size() < 8);
      check("load_ready", 32'(load_ready), 32'(ready_m));
      vis    = (frames < FLASH_ON);
      starve = 1'b0;
      if (pixel_en) begin
         if (exp_q.size() > 0) begin
            p       = exp_q.pop_front();
            exp_vga = colour_of(p, vis, reveal, blank);
         end else begin
            starve  = 1'b1;
            exp_vga = 12'h000;
         end
      end
      exp_underrun = (exp_underrun && !clear_underrun) || starve;
      last_accept  = load_valid && ready_m;
      if (last_accept) push_slice(row_pixels, fg_color, bg_color, flash, conceal);
      if (frame_start) frames = (frames + 1) % (FLASH_ON + FLASH_OFF);
      @(posedge clk);
      #1;
      check("vga", 32'({vga_r, vga_g, vga_b}), 32'(exp_vga));
      check("underrun", 32'(underrun), 32'(exp_underrun));
      @(negedge clk);
   endtask

   // Asynchronous reset asserted between clock edges.
   task automatic do_reset();
      reset_n = 1'b0;
      #2;
      check("rst_vga", 32'({vga_r, vga_g, vga_b}), 32'h0);
      check("rst_load_ready", 32'(load_ready), 32'h1);
      check("rst_underrun", 32'(underrun), 32'h0);
      check("rst_count", 32'(dbg_count), 32'h0);
      exp_q.delete();
      frames       = 0;
      exp_vga      = 12'h000;
      exp_underrun = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic load_slice(input logic [7:0] row, input logic [2:0] fg,
                             input logic [2:0] bg, input logic fl, input logic cn);
      row_pixels = row;
      fg_color   = fg;
      bg_color   = bg;
      flash      = fl;
      conceal    = cn;
      load_valid = 1'b1;
      tick();
      check("load_accept", 32'(last_accept), 32'h1);
      load_valid = 1'b0;
   endtask

   task automatic pixel();
      pixel_en = 1'b1;
      tick();
      pixel_en = 1'b0;
   endtask

   logic [3:0] ser_r[8] = '{4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF};
   logic [3:0] ser_b[8] = '{4'h0, 4'hF, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0};
   logic [7:0] pat;
   bit         b_done;

   initial begin
      idle();
      frames       = 0;
      exp_vga      = 12'h000;
      exp_underrun = 1'b0;
      @(negedge clk);

      // Reset, then an underrun with nothing loaded
      do_reset();
      pixel();
      check("first_underrun", 32'(underrun), 32'h1);
      check("first_vga", 32'({vga_r, vga_g, vga_b}), 32'h0);
      clear_underrun = 1'b1;
      tick();
      clear_underrun = 1'b0;

      // Serialization of 1010_0001, red on blue
      load_slice(8'b1010_0001, 3'b001, 3'b100, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         pixel();
         check("ser_r", 32'(vga_r), 32'(ser_r[i]));
         check("ser_b", 32'(vga_b), 32'(ser_b[i]));
      end

      // Back-to-back slices with pixel_en every cycle
      do_reset();
      load_slice(8'hFF, 3'd7, 3'd0, 1'b0, 1'b0);
      row_pixels = 8'h00;
      fg_color   = 3'd5;
      bg_color   = 3'd2;
      b_done     = 1'b0;
      for (int i = 0; i < 16; i++) begin
         pixel_en   = 1'b1;
         load_valid = !b_done;
         tick();
         if (last_accept) b_done = 1'b1;
         check("b2b_pixel", 32'({vga_r, vga_g, vga_b}), (i < 8) ? 32'hFFF : 32'h0F0);
      end
      pixel_en   = 1'b0;
      load_valid = 1'b0;
      check("b2b_no_underrun", 32'(underrun), 32'h0);

      // Flash phase
      do_reset();
      load_slice(8'hFF, 3'd7, 3'd0, 1'b1, 1'b0);
      frame_start = 1'b1;
      repeat (FLASH_ON) tick();
      frame_start = 1'b0;
      pixel();
      check("flash_hidden", 32'({vga_r, vga_g, vga_b}), 32'h000);
      frame_start = 1'b1;
      repeat (FLASH_OFF) tick();
      frame_start = 1'b0;
      pixel();
      check("flash_shown", 32'({vga_r, vga_g, vga_b}), 32'hFFF);

      // Conceal, reveal and blank on the same slice
      do_reset();
      pat = 8'hC3;
      load_slice(pat, 3'd7, 3'd1, 1'b0, 1'b1);
      for (int i = 7; i >= 0; i--) begin
         pixel();
         check("conceal", 32'({vga_r, vga_g, vga_b}), 32'hF00);
      end
      reveal = 1'b1;
      load_slice(pat, 3'd7, 3'd1, 1'b0, 1'b1);
      for (int i = 7; i >= 0; i--) begin
         pixel();
         check("reveal", 32'({vga_r, vga_g, vga_b}), pat[i] ? 32'hFFF : 32'hF00);
      end
      blank = 1'b1;
      load_slice(pat, 3'd7, 3'd1, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         pixel();
         check("blank", 32'({vga_r, vga_g, vga_b}), 32'h000);
         if (i == 2) check("blank_count_mid", 32'(dbg_count), 32'h5);
      end
      check("blank_count_end", 32'(dbg_count), 32'h0);
      blank  = 1'b0;
      reveal = 1'b0;

      // Reset in the middle of a slice with the holding register full
      do_reset();
      load_slice(8'hFF, 3'd7, 3'd7, 1'b0, 1'b0);
      pixel();
      load_slice(8'hFF, 3'd7, 3'd7, 1'b0, 1'b0);
      pixel();
      pixel();
      check("mid_count", 32'(dbg_count), 32'h5);
      do_reset();
      check("mid_load_ready", 32'(load_ready), 32'h1);
      check("mid_count_clr", 32'(dbg_count), 32'h0);
      pixel();
      check("mid_underrun", 32'(underrun), 32'h1);
      for (int i = 0; i < 4; i++) begin
         pixel();
         check("mid_black", 32'({vga_r, vga_g, vga_b}), 32'h000);
      end

      // Randomized traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         row_pixels     = 8'($urandom);
         fg_color       = 3'($urandom_range(0, 7));
         bg_color       = 3'($urandom_range(0, 7));
         flash          = 1'($urandom_range(0, 1));
         conceal        = ($urandom_range(0, 3) == 0);
         load_valid     = 1'($urandom_range(0, 1));
         pixel_en       = ($urandom_range(0, 3) != 0);
         blank          = ($urandom_range(0, 7) == 0);
         frame_start    = ($urandom_range(0, 7) == 0);
         reveal         = 1'($urandom_range(0, 1));
         clear_underrun = ($urandom_range(0, 15) == 0);
         tick();
      end
      idle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
